// File: rtl/tri_stream_if.sv
// Triangle stream bundle: loader-side push port and rasterizer-side output port.
// The driver takes the master view; the loader/rasterizer environment takes the slave view.
interface tri_stream_if #(
   parameter int SIGFIG = 24,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
);
   logic                     load_valid;
   logic                     load_ready;
   logic signed [SIGFIG-1:0] load_tri [VERTS][AXIS];
   logic        [SIGFIG-1:0] load_color [COLORS];
   logic                     load_last;
   logic signed [SIGFIG-1:0] tri_R10S [VERTS][AXIS];
   logic        [SIGFIG-1:0] color_R10U [COLORS];
   logic                     validTri_R10H;
   logic                     halt_RnnnnL;

   modport master (
      input  load_valid, load_tri, load_color, load_last, halt_RnnnnL,
      output load_ready, tri_R10S, color_R10U, validTri_R10H
   );

   modport slave (
      output load_valid, load_tri, load_color, load_last, halt_RnnnnL,
      input  load_ready, tri_R10S, color_R10U, validTri_R10H
   );
endinterface

// File: rtl/tri_stream_driver.sv
// Buffers loaded triangles in a small FIFO and streams them to the rasterizer
// with a valid/halt handshake, counting deliveries and flagging the last one.
module tri_stream_driver #(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   tri_stream_if.master               bus,
   output logic [31:0]                tri_count,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       done
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   // Elaboration-time guards on the parameter set.
   if (RADIX >= SIGFIG) begin : g_bad_radix
      $error("RADIX must leave at least one integer bit");
   end
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("DEPTH must be a power of 2 and at least 2");
   end

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   state_t                   r_state;
   logic signed [SIGFIG-1:0] r_fifo_tri   [DEPTH][VERTS][AXIS];
   logic        [SIGFIG-1:0] r_fifo_color [DEPTH][COLORS];
   logic                     r_fifo_last  [DEPTH];
   logic [PW-1:0]            r_wr_ptr;
   logic [PW-1:0]            r_rd_ptr;
   logic [LW-1:0]            r_level;
   logic                     r_last_seen;
   logic signed [SIGFIG-1:0] r_out_tri   [VERTS][AXIS];
   logic        [SIGFIG-1:0] r_out_color [COLORS];
   logic                     r_out_last;
   logic                     r_valid;
   logic [31:0]              r_tri_count;
   logic                     r_done;

   logic w_full;
   logic w_empty;
   logic w_load_ready;
   logic w_push;
   logic w_xfer;
   logic w_pop;

   assign w_full  = (r_level == LW'(DEPTH));
   assign w_empty = (r_level == '0);
   // A full FIFO refuses even when a pop frees a slot this cycle: no bypass.
   assign w_load_ready = rst && !w_full && (r_state != DONE) && !r_last_seen;
   assign w_push = bus.load_valid && w_load_ready;
   assign w_xfer = r_valid && bus.halt_RnnnnL;
   assign w_pop  = (!r_valid || w_xfer) && !w_empty;

   // NOTE: storage arrays carry no reset; the pointers and level define which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_tri[r_wr_ptr]   <= bus.load_tri;
         r_fifo_color[r_wr_ptr] <= bus.load_color;
         r_fifo_last[r_wr_ptr]  <= bus.load_last;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_last_seen <= 1'b0;
         r_out_tri   <= '{default: '0};
         r_out_color <= '{default: '0};
         r_out_last  <= 1'b0;
         r_valid     <= 1'b0;
         r_tri_count <= '0;
         r_done      <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (bus.load_last) r_last_seen <= 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         if (w_xfer) r_tri_count <= r_tri_count + 32'd1;

         // Refill the output register on an empty slot or on the edge its contents leave.
         if (w_pop) begin
            r_out_tri   <= r_fifo_tri[r_rd_ptr];
            r_out_color <= r_fifo_color[r_rd_ptr];
            r_out_last  <= r_fifo_last[r_rd_ptr];
            r_valid     <= 1'b1;
         end else if (w_xfer) begin
            r_valid <= 1'b0;
         end

         case (r_state)
            IDLE:    if (w_push) r_state <= STREAM;
            STREAM:  if (w_xfer && r_out_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                     end
            default: r_state <= r_state;
         endcase
      end
   end

   assign bus.load_ready    = w_load_ready;
   assign bus.tri_R10S      = r_out_tri;
   assign bus.color_R10U    = r_out_color;
   assign bus.validTri_R10H = r_valid;
   assign tri_count         = r_tri_count;
   assign fifo_level        = r_level;
   assign done              = r_done;
endmodule
